// File: rtl/axi4lite_pkg.sv
// Shared constants for the AXI4-Lite register responder: response codes,
// register indices and the write-side state encoding.
package axi4lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int REG0        = 0;
  localparam int REG1        = 1;
  localparam int REG2        = 2;
  localparam int WCNT        = 3;
  localparam int NUM_RW_REGS = 3;

  typedef enum logic {
    W_COLLECT = 1'b0,
    W_RESP    = 1'b1
  } wr_state_t;

endpackage

// File: rtl/axi4lite_wr_collect.sv
// One-entry holding buffers for the AW and W channels; reports when a complete
// write (address plus data, held or arriving this cycle) is available.
module axi4lite_wr_collect
  import axi4lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  i_clk,
  input  logic                  i_srst,
  input  logic                  i_accept,
  input  logic                  i_clear,
  input  logic [ADDR_WIDTH-1:0] i_awaddr,
  input  logic                  i_awvalid,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [STRB_WIDTH-1:0] i_wstrb,
  input  logic                  i_wvalid,
  output logic                  o_awready,
  output logic                  o_wready,
  output logic                  o_both_avail,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [STRB_WIDTH-1:0] o_strb
);

  logic                  r_aw_full;
  logic                  r_w_full;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_WIDTH-1:0] r_wstrb;
  logic                  w_aw_avail;
  logic                  w_w_avail;

  assign o_awready = i_accept && !r_aw_full;
  assign o_wready  = i_accept && !r_w_full;

  assign w_aw_avail   = r_aw_full || (i_awvalid && o_awready);
  assign w_w_avail    = r_w_full  || (i_wvalid  && o_wready);
  assign o_both_avail = i_accept && w_aw_avail && w_w_avail;

  // A held beat takes priority over the live bus value.
  assign o_addr = r_aw_full ? r_awaddr : i_awaddr;
  assign o_data = r_w_full  ? r_wdata  : i_wdata;
  assign o_strb = r_w_full  ? r_wstrb  : i_wstrb;

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_aw_full <= 1'b0;
      r_awaddr  <= '0;
    end else if (i_clear) begin
      r_aw_full <= 1'b0;
    end else if (i_awvalid && o_awready) begin
      r_aw_full <= 1'b1;
      r_awaddr  <= i_awaddr;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_w_full <= 1'b0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
    end else if (i_clear) begin
      r_w_full <= 1'b0;
    end else if (i_wvalid && o_wready) begin
      r_w_full <= 1'b1;
      r_wdata  <= i_wdata;
      r_wstrb  <= i_wstrb;
    end
  end

endmodule

// File: rtl/axi4lite_reg_responder.sv
// AXI4-Lite slave exposing three RW registers and a read-only count of
// successful writes; read and write paths run independently.
module axi4lite_reg_responder
  import axi4lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_areset,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [STRB_WIDTH-1:0]   s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [3*DATA_WIDTH-1:0] regs_o
);

  wr_state_t                                r_state;
  wr_state_t                                w_state_next;
  logic                                     w_both;
  logic                                     w_commit;
  logic [ADDR_WIDTH-1:0]                    w_wr_addr;
  logic [DATA_WIDTH-1:0]                    w_wr_data;
  logic [STRB_WIDTH-1:0]                    w_wr_strb;
  logic                                     w_wr_mapped;
  logic                                     w_wr_rw;
  logic [1:0]                               w_wr_idx;
  logic [1:0]                               r_bresp;
  logic [NUM_RW_REGS-1:0][DATA_WIDTH-1:0]   w_regs;
  logic [DATA_WIDTH-1:0]                    r_wcnt;
  logic                                     w_rd_mapped;
  logic [1:0]                               w_rd_idx;
  logic [DATA_WIDTH-1:0]                    w_rd_data;
  logic                                     r_rvalid;
  logic [DATA_WIDTH-1:0]                    r_rdata;
  logic [1:0]                               r_rresp;

  axi4lite_wr_collect #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_wr_collect (
    .i_clk        (s_axi_aclk),
    .i_srst       (s_axi_areset),
    .i_accept     ((r_state == W_COLLECT) && !s_axi_areset),
    .i_clear      (w_commit),
    .i_awaddr     (s_axi_awaddr),
    .i_awvalid    (s_axi_awvalid),
    .i_wdata      (s_axi_wdata),
    .i_wstrb      (s_axi_wstrb),
    .i_wvalid     (s_axi_wvalid),
    .o_awready    (s_axi_awready),
    .o_wready     (s_axi_wready),
    .o_both_avail (w_both),
    .o_addr       (w_wr_addr),
    .o_data       (w_wr_data),
    .o_strb       (w_wr_strb)
  );

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) r_state <= W_COLLECT;
    else              r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      W_COLLECT: if (w_both)       w_state_next = W_RESP;
      W_RESP:    if (s_axi_bready) w_state_next = W_COLLECT;
      default:                     w_state_next = W_COLLECT;
    endcase
  end

  assign w_commit    = (r_state == W_COLLECT) && w_both;
  // Anything above the four-register window decodes as unmapped.
  assign w_wr_mapped = (w_wr_addr >> 2) == '0;
  assign w_wr_idx    = w_wr_addr[1:0];
  assign w_wr_rw     = w_wr_mapped && (w_wr_idx != 2'(WCNT));

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      r_bresp <= RESP_OKAY;
    end else if (w_commit) begin
      if (w_wr_rw)          r_bresp <= RESP_OKAY;
      else if (w_wr_mapped) r_bresp <= RESP_SLVERR;
      else                  r_bresp <= RESP_DECERR;
    end
  end

  assign s_axi_bvalid = (r_state == W_RESP);
  assign s_axi_bresp  = r_bresp;

  for (genvar gi = 0; gi < NUM_RW_REGS; gi++) begin : g_reg
    logic [DATA_WIDTH-1:0] r_reg;

    always_ff @(posedge s_axi_aclk) begin
      if (s_axi_areset) begin
        r_reg <= '0;
      end else if (w_commit && w_wr_rw && (w_wr_idx == 2'(gi))) begin
        for (int b = 0; b < STRB_WIDTH; b++) begin
          if (w_wr_strb[b]) r_reg[b*8 +: 8] <= w_wr_data[b*8 +: 8];
        end
      end
    end

    assign w_regs[gi] = r_reg;
  end

  // Every OKAY write counts, even one with no strobes set.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset)            r_wcnt <= '0;
    else if (w_commit && w_wr_rw) r_wcnt <= r_wcnt + DATA_WIDTH'(1);
  end

  assign regs_o = w_regs;

  assign w_rd_mapped = (s_axi_araddr >> 2) == '0;
  assign w_rd_idx    = s_axi_araddr[1:0];

  always_comb begin
    w_rd_data = '0;
    if (w_rd_mapped) begin
      case (w_rd_idx)
        2'(REG0): w_rd_data = w_regs[REG0];
        2'(REG1): w_rd_data = w_regs[REG1];
        2'(REG2): w_rd_data = w_regs[REG2];
        default:  w_rd_data = r_wcnt;
      endcase
    end
  end

  assign s_axi_arready = !r_rvalid && !s_axi_areset;

  // Sampling registers at the AR edge returns pre-write data on a same-edge commit.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else if (s_axi_arvalid && s_axi_arready) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_data;
      r_rresp  <= w_rd_mapped ? RESP_OKAY : RESP_DECERR;
    end else if (r_rvalid && s_axi_rready) begin
      r_rvalid <= 1'b0;
    end
  end

  assign s_axi_rvalid = r_rvalid;
  assign s_axi_rdata  = r_rdata;
  assign s_axi_rresp  = r_rresp;

endmodule

// File: tb/tb_axi4lite_reg_responder.sv
// Directed bench for the AXI4-Lite register responder (ADDR_WIDTH=3 so the
// unmapped window is reachable).
module tb_axi4lite_reg_responder;

  logic        clk;
  logic        areset;
  logic [2:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [7:0]  wdata;
  logic [0:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [2:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [7:0]  rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [23:0] regs_o;

  int errors;
  int checks;
  int exp_wcnt;

  axi4lite_reg_responder #(
    .ADDR_WIDTH (3),
    .DATA_WIDTH (8)
  ) dut (
    .s_axi_aclk    (clk),
    .s_axi_areset  (areset),
    .s_axi_awaddr  (awaddr),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_araddr  (araddr),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .regs_o        (regs_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Full write: AW and W presented together, then B collected with bready high.
  task automatic axi_write(input logic [2:0] a, input logic [7:0] d, input logic [0:0] s,
                           output logic [1:0] resp, output bit ok);
    bit awd;
    bit wd;
    int n;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    awd = 1'b0; wd = 1'b0; n = 0;
    while (!(awd && wd) && n < 20) begin
      @(negedge clk);
      if (awvalid && awready) awd = 1'b1;
      if (wvalid && wready) wd = 1'b1;
      @(posedge clk); #1;
      if (awd) awvalid = 1'b0;
      if (wd) wvalid = 1'b0;
      n++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    bready = 1'b1; ok = 1'b0; n = 0; resp = 2'b01;
    while (!ok && n < 20) begin
      @(negedge clk);
      if (bvalid) begin ok = 1'b1; resp = bresp; end
      @(posedge clk); #1;
      n++;
    end
    bready = 1'b0;
    ok = ok && awd && wd;
    $display("write addr=%0d data=%02h strb=%0b resp=%0d done=%0d", a, d, s, resp, ok);
  endtask

  task automatic axi_read(input logic [2:0] a, output logic [7:0] data,
                          output logic [1:0] resp, output bit ok);
    bit ard;
    int n;
    araddr = a; arvalid = 1'b1; ard = 1'b0; n = 0;
    data = 8'h00; resp = 2'b01;
    while (!ard && n < 20) begin
      @(negedge clk);
      if (arready) ard = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    arvalid = 1'b0;
    rready = 1'b1; ok = 1'b0; n = 0;
    while (!ok && n < 20) begin
      @(negedge clk);
      if (rvalid) begin ok = 1'b1; data = rdata; resp = rresp; end
      @(posedge clk); #1;
      n++;
    end
    rready = 1'b0;
    ok = ok && ard;
    $display("read  addr=%0d data=%02h resp=%0d done=%0d", a, data, resp, ok);
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %05b expected 00000", {awready, wready, arready, bvalid, rvalid});
    end
    checks++;
    if ({regs_o, rdata, rresp, bresp} !== 36'h0) begin
      errors++;
      $display("FAIL reset_data: got regs=%06h rdata=%02h rresp=%0d bresp=%0d expected all 0", regs_o, rdata, rresp, bresp);
    end
    @(posedge clk); #1;
    areset = 1'b0;
    @(negedge clk);
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      errors++;
      $display("FAIL reset_release_ready: got %03b expected 111", {awready, wready, arready});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [7:0] d;
    logic [1:0] r;
    bit ok;
    awaddr = 3'd1; wdata = 8'hA5; wstrb = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    checks++;
    if ({awready, wready, bvalid} !== 3'b110) begin
      errors++;
      $display("FAIL basic_accept: got aw/w/b=%03b expected 110", {awready, wready, bvalid});
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    checks++;
    if ({bvalid, bresp} !== 3'b100) begin
      errors++;
      $display("FAIL basic_b_latency: got bvalid=%0b bresp=%0d expected 1 0", bvalid, bresp);
    end
    checks++;
    if (regs_o !== 24'h00A500) begin
      errors++;
      $display("FAIL basic_regs_o: got %06h expected 00a500", regs_o);
    end
    @(posedge clk); #1;
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    @(negedge clk);
    checks++;
    if (bvalid !== 1'b0) begin
      errors++;
      $display("FAIL basic_b_done: got bvalid=%0b expected 0", bvalid);
    end
    @(posedge clk); #1;
    exp_wcnt = 1;
    axi_read(3'd1, d, r, ok);
    checks++;
    if ({ok, r, d} !== {1'b1, 2'b00, 8'hA5}) begin
      errors++;
      $display("FAIL basic_read_reg1: got ok=%0b resp=%0d data=%02h expected 1 0 a5", ok, r, d);
    end
    axi_read(3'd3, d, r, ok);
    checks++;
    if ({ok, r, d} !== {1'b1, 2'b00, 8'h01}) begin
      errors++;
      $display("FAIL basic_read_wcnt: got ok=%0b resp=%0d data=%02h expected 1 0 01", ok, r, d);
    end
  endtask

  task automatic test_staggered();
    logic [7:0] d;
    logic [1:0] r;
    bit ok;
    wdata = 8'h3C; wstrb = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    checks++;
    if (wready !== 1'b1) begin
      errors++;
      $display("FAIL stag_w_accept: got wready=%0b expected 1", wready);
    end
    @(posedge clk); #1;
    wvalid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({wready, awready, bvalid} !== 3'b010) begin
        errors++;
        $display("FAIL stag_w_held: got w/aw/b=%03b expected 010", {wready, awready, bvalid});
      end
      @(posedge clk); #1;
    end
    awaddr = 3'd2; awvalid = 1'b1;
    @(negedge clk);
    checks++;
    if ({wready, awready, bvalid} !== 3'b010) begin
      errors++;
      $display("FAIL stag_aw_cycle: got w/aw/b=%03b expected 010", {wready, awready, bvalid});
    end
    @(posedge clk); #1;
    awvalid = 1'b0;
    @(negedge clk);
    checks++;
    if ({bvalid, bresp, regs_o[23:16]} !== {1'b1, 2'b00, 8'h3C}) begin
      errors++;
      $display("FAIL stag_commit: got bvalid=%0b bresp=%0d reg2=%02h expected 1 0 3c", bvalid, bresp, regs_o[23:16]);
    end
    @(posedge clk); #1;
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    exp_wcnt = 2;
    axi_read(3'd2, d, r, ok);
    checks++;
    if ({ok, r, d} !== {1'b1, 2'b00, 8'h3C}) begin
      errors++;
      $display("FAIL stag_read_reg2: got ok=%0b resp=%0d data=%02h expected 1 0 3c", ok, r, d);
    end
  endtask

  task automatic test_errors();
    logic [7:0] d;
    logic [1:0] r;
    bit ok;
    axi_write(3'd3, 8'hFF, 1'b1, r, ok);
    checks++;
    if ({ok, r} !== {1'b1, 2'b10}) begin
      errors++;
      $display("FAIL err_wcnt_write: got ok=%0b resp=%0d expected 1 2", ok, r);
    end
    axi_write(3'd6, 8'h77, 1'b1, r, ok);
    checks++;
    if ({ok, r} !== {1'b1, 2'b11}) begin
      errors++;
      $display("FAIL err_unmapped_write: got ok=%0b resp=%0d expected 1 3", ok, r);
    end
    axi_read(3'd6, d, r, ok);
    checks++;
    if ({ok, r, d} !== {1'b1, 2'b11, 8'h00}) begin
      errors++;
      $display("FAIL err_unmapped_read: got ok=%0b resp=%0d data=%02h expected 1 3 00", ok, r, d);
    end
    axi_write(3'd0, 8'hEE, 1'b0, r, ok);
    exp_wcnt = 3;
    checks++;
    if ({ok, r, regs_o} !== {1'b1, 2'b00, 24'h3CA500}) begin
      errors++;
      $display("FAIL err_zero_strb: got ok=%0b resp=%0d regs=%06h expected 1 0 3ca500", ok, r, regs_o);
    end
    axi_read(3'd3, d, r, ok);
    checks++;
    if ({ok, r, d} !== {1'b1, 2'b00, 8'h03}) begin
      errors++;
      $display("FAIL err_wcnt_value: got ok=%0b resp=%0d data=%02h expected 1 0 03", ok, r, d);
    end
  endtask

  task automatic test_same_edge();
    logic [7:0] d;
    logic [1:0] r;
    bit ok;
    axi_write(3'd0, 8'h11, 1'b1, r, ok);
    awaddr = 3'd0; wdata = 8'h22; wstrb = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 3'd0; arvalid = 1'b1;
    @(negedge clk);
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      errors++;
      $display("FAIL same_accept: got aw/w/ar=%03b expected 111", {awready, wready, arready});
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    checks++;
    if ({rvalid, rresp, rdata} !== {1'b1, 2'b00, 8'h11}) begin
      errors++;
      $display("FAIL same_old_value: got rvalid=%0b rresp=%0d rdata=%02h expected 1 0 11", rvalid, rresp, rdata);
    end
    checks++;
    if ({bvalid, regs_o[7:0]} !== {1'b1, 8'h22}) begin
      errors++;
      $display("FAIL same_commit: got bvalid=%0b reg0=%02h expected 1 22", bvalid, regs_o[7:0]);
    end
    @(posedge clk); #1;
    bready = 1'b1; rready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0; rready = 1'b0;
    exp_wcnt = 5;
    axi_read(3'd0, d, r, ok);
    checks++;
    if ({ok, r, d} !== {1'b1, 2'b00, 8'h22}) begin
      errors++;
      $display("FAIL same_new_value: got ok=%0b resp=%0d data=%02h expected 1 0 22", ok, r, d);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] d;
    logic [1:0] r;
    bit ok;
    awaddr = 3'd1; wdata = 8'h5A; wstrb = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    wdata = 8'hC3;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({bvalid, bresp, awready, wready, arready} !== 6'b100001) begin
        errors++;
        $display("FAIL bp_stall_%0d: got b=%0b resp=%0d aw=%0b w=%0b ar=%0b expected 1 0 0 0 1",
                 i, bvalid, bresp, awready, wready, arready);
      end
      @(posedge clk); #1;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    axi_read(3'd1, d, r, ok);
    checks++;
    if ({ok, r, d, bvalid} !== {1'b1, 2'b00, 8'h5A, 1'b1}) begin
      errors++;
      $display("FAIL bp_concurrent_read: got ok=%0b resp=%0d data=%02h bvalid=%0b expected 1 0 5a 1", ok, r, d, bvalid);
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    exp_wcnt = 6;
    @(negedge clk);
    checks++;
    if ({bvalid, awready, wready} !== 3'b011) begin
      errors++;
      $display("FAIL bp_release: got b/aw/w=%03b expected 011", {bvalid, awready, wready});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_wcnt_wrap();
    logic [7:0] d;
    logic [1:0] r;
    bit ok;
    int bad;
    bad = 0;
    while (exp_wcnt < 255) begin
      axi_write(3'd2, 8'hFF, 1'b0, r, ok);
      if (!ok || r !== 2'b00) bad++;
      exp_wcnt++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL wrap_fill: got %0d bad responses expected 0", bad);
    end
    axi_read(3'd3, d, r, ok);
    checks++;
    if ({ok, r, d} !== {1'b1, 2'b00, 8'hFF}) begin
      errors++;
      $display("FAIL wrap_at_255: got ok=%0b resp=%0d data=%02h expected 1 0 ff", ok, r, d);
    end
    axi_write(3'd2, 8'hFF, 1'b0, r, ok);
    axi_read(3'd3, d, r, ok);
    checks++;
    if ({ok, r, d, regs_o} !== {1'b1, 2'b00, 8'h00, 24'h3C5A22}) begin
      errors++;
      $display("FAIL wrap_to_0: got ok=%0b resp=%0d data=%02h regs=%06h expected 1 0 00 3c5a22", ok, r, d, regs_o);
    end
  endtask

  task automatic test_reset_mid();
    awaddr = 3'd0; awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    @(negedge clk);
    checks++;
    if ({awready, wready, bvalid} !== 3'b010) begin
      errors++;
      $display("FAIL rmid_aw_held: got aw/w/b=%03b expected 010", {awready, wready, bvalid});
    end
    @(posedge clk); #1;
    areset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata, regs_o} !== 41'h0) begin
      errors++;
      $display("FAIL rmid_outputs: got aw=%0b w=%0b ar=%0b b=%0b r=%0b regs=%06h expected all 0",
               awready, wready, arready, bvalid, rvalid, regs_o);
    end
    @(posedge clk); #1;
    areset = 1'b0;
    wdata = 8'h99; wstrb = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      errors++;
      $display("FAIL rmid_ready_rise: got aw/w/ar=%03b expected 111", {awready, wready, arready});
    end
    @(posedge clk); #1;
    wvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({bvalid, regs_o} !== 25'h0) begin
        errors++;
        $display("FAIL rmid_no_commit_%0d: got bvalid=%0b regs=%06h expected 0 000000", i, bvalid, regs_o);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    errors = 0; checks = 0; exp_wcnt = 0;
    areset = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    test_reset();
    test_basic();
    test_staggered();
    test_errors();
    test_same_edge();
    test_backpressure();
    test_wcnt_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
